extended_hamming_block_codec: RTL and testbench
===============================================

# extended_hamming_block_codec

Registered extended-Hamming (SECDED) block unit for a DATA_WIDTH-bit datapath. It has two independent channels. The pack channel places data and a precomputed code into the canonical block layout. The check/correct channel flags, locates and repairs single-bit errors in a received block and flags double-bit errors. It sits between a memory or link and its client, on the write side (pack) and the read side (check/correct).

## Interface
Parameters:
- DATA_WIDTH, 8, number of payload bits (≥ 4).
- PARITY_WIDTH, derived, r + 1, where r is the smallest integer with 2^r ≥ DATA_WIDTH + r + 1. This gives 5 for DATA_WIDTH = 8.
- BLOCK_WIDTH, derived, DATA_WIDTH + PARITY_WIDTH. This gives 13 for DATA_WIDTH = 8.

Ports:
- clock  in  1  sole clock; one clock domain, all outputs update on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pack_valid  in  1  pack request.
- pack_data  in  DATA_WIDTH  payload.
- pack_code  in  PARITY_WIDTH  code for pack_data.
- pack_block_valid  out  1  registered pack_valid.
- pack_block  out  BLOCK_WIDTH  packed block.
- check_valid  in  1  check request.
- check_block  in  BLOCK_WIDTH  received block.
- result_valid  out  1  registered check_valid.
- error  out  1  any error detected (single or double).
- uncorrectable  out  1  the error cannot be corrected.
- corrected_block  out  BLOCK_WIDTH  repaired block.
- corrected_count, uncorrectable_count  out  16  present only with EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN.

## Operation
Block layout:
- Bit 0 = code[PARITY_WIDTH-1], the overall even parity over block bits 1..BLOCK_WIDTH-1.
- Bit 2^k = code[k] for k < PARITY_WIDTH-1.
- The remaining positions hold data bits in ascending order: data[0] at bit 3, data[3:1] at bits 7:5, data[10:4] at bits 15:9, and so on.
- Pack: pack_block is pack_data and pack_code placed per this layout. The code is not recomputed or checked.

Check/correct:
- Syndrome S is the XOR of the indices of all set bits in positions 1..BLOCK_WIDTH-1.
- P is the XOR of all BLOCK_WIDTH bits.
- Decoding rules:
  - S = 0, P = 0: no error; error = 0, uncorrectable = 0, corrected_block = check_block.
  - P = 1, S = 0: the parity bit is flipped; error = 1, correct bit 0.
  - P = 1, 0 < S < BLOCK_WIDTH: single-bit error; error = 1, flip bit S.
  - P = 1, S ≥ BLOCK_WIDTH: error = 1, uncorrectable = 1, block passed unmodified.
  - P = 0, S ≠ 0: double-bit error; error = 1, uncorrectable = 1, block passed unmodified.
- Triple or higher errors are outside the guarantee.

## Timing
- Both channels are fully registered with a latency of exactly 1 cycle and no backpressure. A new request is accepted every cycle.
- The two channels are independent. Simultaneous pack_valid and check_valid are both served in the same cycle.
- Data outputs load only when the corresponding valid is high and hold otherwise. The valid outputs follow their inputs every cycle.
- Reset forces all outputs (valids, flags, blocks, counters) to 0 immediately. An in-flight request during reset is dropped. The first valid output can appear one cycle after reset deasserts and a request is presented.

## Configuration
- EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN defined:
  - Adds corrected_count, incremented on each result with error = 1 and uncorrectable = 0.
  - Adds uncorrectable_count, incremented on each result with uncorrectable = 1.
  - Both counters are 16 bits, saturate at 0xFFFF, clear on reset, and update in the same cycle as result_valid.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Package extended_hamming_pkg contains:
  - the parity-width function and the BLOCK_WIDTH derivation;
  - a function mapping a data index to its block position;
  - an is-power-of-two position helper.
- Sub-module extended_hamming_syndrome: combinational block in, S and P out. It is instantiated once for the check channel.
- Packing is inline generate logic using the package mapping.

## Test plan
All values use DATA_WIDTH = 8.
- Pack: pack_data = 8'h01, pack_code = 5'b10011, pack_valid = 1 → next cycle pack_block_valid = 1, pack_block = 13'h000F.
- Clean check: check_block = 13'h000F → error = 0, uncorrectable = 0, corrected_block = 13'h000F; also sweep all 256 encoded blocks clean.
- Single-bit errors:
  - 13'h002F (bit 5 flipped) → error = 1, uncorrectable = 0, corrected_block = 13'h000F.
  - 13'h000E (bit 0 flipped) → corrected_block = 13'h000F.
  - Exhaustive: every data value × every single-bit position.
- Double error: 13'h006F (bits 5 and 6 flipped) → error = 1, uncorrectable = 1, corrected_block = 13'h006F.
- Reset: assert reset while check_valid = 1 → result_valid and all outputs read 0 immediately; after deassert, a new request completes with 1-cycle latency.
- With EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN: 3 single errors and 2 double errors → corrected_count = 3, uncorrectable_count = 2; the counters saturate at 0xFFFF.

Source files
------------

// File: rtl/extended_hamming_block_codec_pkg.sv
// Shared sizing and block-layout helpers for the extended Hamming (SECDED) codec.
package extended_hamming_pkg;

    // r + 1, where r is the smallest value with 2^r >= data_width + r + 1
    function automatic int parity_width(input int data_width);
        int r;
        r = 1;
        while ((1 << r) < data_width + r + 1)
            r++;
        return r + 1;
    endfunction

    function automatic int block_width(input int data_width);
        return data_width + parity_width(data_width);
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data bits fill the non-power-of-two positions from bit 3 upward
    function automatic int data_position(input int data_index);
        int pos;
        int count;
        pos   = 2;
        count = -1;
        while (count < data_index) begin
            pos++;
            if (!is_pow2(pos))
                count++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/extended_hamming_block_codec_if.sv
// Pack and check/correct request/result bundle for extended_hamming_block_codec.
interface extended_hamming_block_codec_if #(
    parameter int DATA_WIDTH = 8
);
    import extended_hamming_pkg::*;

    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH);
    localparam int BLOCK_WIDTH  = block_width(DATA_WIDTH);

    logic                    pack_valid;
    logic [DATA_WIDTH-1:0]   pack_data;
    logic [PARITY_WIDTH-1:0] pack_code;
    logic                    pack_block_valid;
    logic [BLOCK_WIDTH-1:0]  pack_block;

    logic                    check_valid;
    logic [BLOCK_WIDTH-1:0]  check_block;
    logic                    result_valid;
    logic                    error;
    logic                    uncorrectable;
    logic [BLOCK_WIDTH-1:0]  corrected_block;

    modport master (
        output pack_valid, pack_data, pack_code, check_valid, check_block,
        input  pack_block_valid, pack_block, result_valid, error, uncorrectable, corrected_block
    );

    modport slave (
        input  pack_valid, pack_data, pack_code, check_valid, check_block,
        output pack_block_valid, pack_block, result_valid, error, uncorrectable, corrected_block
    );

endinterface

// File: rtl/extended_hamming_block_codec_syndrome.sv
// Combinational syndrome (XOR of set-bit indices 1..N-1) and overall parity of a block.
module extended_hamming_syndrome #(
    parameter int BLOCK_WIDTH = 13,
    parameter int SYN_WIDTH   = 4
) (
    input  logic [BLOCK_WIDTH-1:0] block,
    output logic [SYN_WIDTH-1:0]   syndrome,
    output logic                   parity
);

    always_comb begin
        syndrome = '0;
        for (int pos = 1; pos < BLOCK_WIDTH; pos++) begin
            if (block[pos])
                syndrome = syndrome ^ SYN_WIDTH'(pos);
        end
    end

    assign parity = ^block;

endmodule

// File: rtl/extended_hamming_block_codec.sv
// Registered SECDED pack and check/correct channels, 1-cycle latency each.
// Optional saturating event counters: EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN.
module extended_hamming_block_codec
    import extended_hamming_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    extended_hamming_block_codec_if.slave bus
`ifdef EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN
    ,
    output logic [15:0] corrected_count,
    output logic [15:0] uncorrectable_count
`endif
);

    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH);
    localparam int BLOCK_WIDTH  = block_width(DATA_WIDTH);
    localparam int SYN_WIDTH    = PARITY_WIDTH - 1;

    wire [BLOCK_WIDTH-1:0] pack_layout;

    assign pack_layout[0] = bus.pack_code[PARITY_WIDTH-1];
    for (genvar k = 0; k < PARITY_WIDTH - 1; k++) begin : g_code
        assign pack_layout[1 << k] = bus.pack_code[k];
    end
    for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_data
        assign pack_layout[data_position(d)] = bus.pack_data[d];
    end

    logic [SYN_WIDTH-1:0]   syndrome;
    logic                   parity;
    logic                   error_d;
    logic                   unc_d;
    logic [BLOCK_WIDTH-1:0] corrected_d;

    extended_hamming_syndrome #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .SYN_WIDTH   (SYN_WIDTH)
    ) u_syndrome (
        .block    (bus.check_block),
        .syndrome (syndrome),
        .parity   (parity)
    );

    // Odd parity with an in-range syndrome is a single error at that bit (S = 0 is bit 0)
    always_comb begin
        error_d     = parity || (syndrome != '0);
        unc_d       = 1'b0;
        corrected_d = bus.check_block;
        if (parity) begin
            if (int'(syndrome) < BLOCK_WIDTH)
                corrected_d = bus.check_block ^ (BLOCK_WIDTH'(1) << syndrome);
            else
                unc_d = 1'b1;
        end else if (syndrome != '0) begin
            unc_d = 1'b1;
        end
    end

    // Stage p1: registered outputs
    logic                   pack_vld_p1;
    logic [BLOCK_WIDTH-1:0] pack_block_p1;
    logic                   result_vld_p1;
    logic                   error_p1;
    logic                   unc_p1;
    logic [BLOCK_WIDTH-1:0] corrected_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pack_vld_p1   <= 1'b0;
            pack_block_p1 <= '0;
            result_vld_p1 <= 1'b0;
            error_p1      <= 1'b0;
            unc_p1        <= 1'b0;
            corrected_p1  <= '0;
        end else begin
            pack_vld_p1   <= bus.pack_valid;
            result_vld_p1 <= bus.check_valid;
            if (bus.pack_valid)
                pack_block_p1 <= pack_layout;
            if (bus.check_valid) begin
                error_p1     <= error_d;
                unc_p1       <= unc_d;
                corrected_p1 <= corrected_d;
            end
        end
    end

    assign bus.pack_block_valid = pack_vld_p1;
    assign bus.pack_block       = pack_block_p1;
    assign bus.result_valid     = result_vld_p1;
    assign bus.error            = error_p1;
    assign bus.uncorrectable    = unc_p1;
    assign bus.corrected_block  = corrected_p1;

`ifdef EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN
    logic [15:0] corrected_cnt_p1;
    logic [15:0] unc_cnt_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            corrected_cnt_p1 <= '0;
            unc_cnt_p1       <= '0;
        end else if (bus.check_valid) begin
            if (error_d && !unc_d && (corrected_cnt_p1 != 16'hFFFF))
                corrected_cnt_p1 <= corrected_cnt_p1 + 16'd1;
            if (unc_d && (unc_cnt_p1 != 16'hFFFF))
                unc_cnt_p1 <= unc_cnt_p1 + 16'd1;
        end
    end

    assign corrected_count     = corrected_cnt_p1;
    assign uncorrectable_count = unc_cnt_p1;
`endif

endmodule

// File: tb/tb_extended_hamming_block_codec.sv
// Scoreboard bench for extended_hamming_block_codec (DATA_WIDTH = 8), random and directed stimulus.
module tb_extended_hamming_block_codec;

    localparam int DW = 8;
    localparam int PW = 5;
    localparam int BW = 13;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    extended_hamming_block_codec_if #(.DATA_WIDTH(DW)) bus ();

`ifdef EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN
    logic [15:0] corrected_count;
    logic [15:0] uncorrectable_count;
`endif

    extended_hamming_block_codec #(.DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN
        ,
        .corrected_count     (corrected_count),
        .uncorrectable_count (uncorrectable_count)
`endif
    );

    typedef struct {
        logic          error;
        logic          unc;
        logic [BW-1:0] block;
    } chk_t;

    chk_t          chk_q[$];
    logic [BW-1:0] pack_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            dpos[DW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: layout from the position rules, codewords by parity equations
    function automatic logic [BW-1:0] place_data(input logic [DW-1:0] d);
        logic [BW-1:0] b = '0;
        for (int i = 0; i < DW; i++) b[dpos[i]] = d[i];
        return b;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [BW-1:0] b);
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++) d[i] = b[dpos[i]];
        return d;
    endfunction

    function automatic logic [BW-1:0] encode(input logic [DW-1:0] d);
        logic [BW-1:0] b = place_data(d);
        for (int k = 0; k < PW - 1; k++) begin
            logic par = 1'b0;
            for (int pos = 1; pos < BW; pos++)
                if (pos != (1 << k) && ((pos >> k) & 1) == 1) par ^= b[pos];
            b[1 << k] = par;
        end
        b[0] = ^b[BW-1:1];
        return b;
    endfunction

    function automatic bit is_codeword(input logic [BW-1:0] b);
        return encode(extract(b)) == b;
    endfunction

    function automatic chk_t decode(input logic [BW-1:0] b);
        chk_t r;
        r.error = 1'b0; r.unc = 1'b0; r.block = b;
        if (!is_codeword(b)) begin
            r.error = 1'b1;
            r.unc   = 1'b1;
            for (int i = 0; i < BW; i++) begin
                logic [BW-1:0] t = b ^ (BW'(1) << i);
                if (is_codeword(t)) begin r.unc = 1'b0; r.block = t; end
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] pack_expect(input logic [DW-1:0] d, input logic [PW-1:0] c);
        logic [BW-1:0] b = place_data(d);
        b[0] = c[PW-1];
        for (int k = 0; k < PW - 1; k++) b[1 << k] = c[k];
        return b;
    endfunction

    function automatic logic [PW-1:0] code_of(input logic [BW-1:0] cw);
        logic [PW-1:0] c;
        c[PW-1] = cw[0];
        for (int k = 0; k < PW - 1; k++) c[k] = cw[1 << k];
        return c;
    endfunction

    task automatic drive_now(input bit pv, input logic [DW-1:0] pd, input logic [PW-1:0] pc,
                             input bit cv, input logic [BW-1:0] cb);
        bus.pack_valid  = pv;
        bus.pack_data   = pd;
        bus.pack_code   = pc;
        bus.check_valid = cv;
        bus.check_block = cb;
        if (pv) pack_q.push_back(pack_expect(pd, pc));
        if (cv) chk_q.push_back(decode(cb));
    endtask

    task automatic issue(input bit pv, input logic [DW-1:0] pd, input logic [PW-1:0] pc,
                         input bit cv, input logic [BW-1:0] cb);
        @(negedge clock);
        drive_now(pv, pd, pc, cv, cb);
    endtask

    task automatic issue_lit(input logic [BW-1:0] cb, input logic e, input logic u, input logic [BW-1:0] corr);
        chk_t r;
        @(negedge clock);
        bus.pack_valid  = 1'b0;
        bus.check_valid = 1'b1;
        bus.check_block = cb;
        r.error = e; r.unc = u; r.block = corr;
        chk_q.push_back(r);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pack_valid"},   32'(bus.pack_block_valid), 0);
        check({tag, "_pack_block"},   32'(bus.pack_block), 0);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 0);
        check({tag, "_error"},        32'(bus.error), 0);
        check({tag, "_uncorr"},       32'(bus.uncorrectable), 0);
        check({tag, "_corrected"},    32'(bus.corrected_block), 0);
`ifdef EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN
        check({tag, "_corr_count"},   32'(corrected_count), 0);
        check({tag, "_unc_count"},    32'(uncorrectable_count), 0);
`endif
    endtask

    // Monitor: pops expectations when outputs are valid, checks hold otherwise
    logic [BW-1:0] held_pack;
    chk_t          held_chk;
    int            exp_corr;
    int            exp_unc;

    initial begin
        held_pack = '0; held_chk = '{1'b0, 1'b0, '0}; exp_corr = 0; exp_unc = 0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                held_pack = '0; held_chk = '{1'b0, 1'b0, '0}; exp_corr = 0; exp_unc = 0;
                pack_q.delete();
                chk_q.delete();
            end else begin
                if (bus.pack_block_valid) begin
                    check("pack_expected", 32'(pack_q.size() != 0), 1);
                    if (pack_q.size() != 0) held_pack = pack_q.pop_front();
                    check("pack_block", 32'(bus.pack_block), 32'(held_pack));
                end else begin
                    check("pack_hold", 32'(bus.pack_block), 32'(held_pack));
                end
                if (bus.result_valid) begin
                    check("result_expected", 32'(chk_q.size() != 0), 1);
                    if (chk_q.size() != 0) begin
                        held_chk = chk_q.pop_front();
                        if (held_chk.error && !held_chk.unc && exp_corr < 65535) exp_corr++;
                        if (held_chk.unc && exp_unc < 65535) exp_unc++;
                    end
                end
                check("error",           32'(bus.error), 32'(held_chk.error));
                check("uncorrectable",   32'(bus.uncorrectable), 32'(held_chk.unc));
                check("corrected_block", 32'(bus.corrected_block), 32'(held_chk.block));
`ifdef EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN
                check("corrected_count",     32'(corrected_count), 32'(exp_corr));
                check("uncorrectable_count", 32'(uncorrectable_count), 32'(exp_unc));
`endif
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int pos = 1, n = 0; pos < BW; pos++)
            if ($countones(pos) != 1) begin dpos[n] = pos; n++; end

        drive_now(1'b0, '0, '0, 1'b0, '0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset = 1'b0;

        // Directed vectors with literal expectations
        @(negedge clock);
        bus.pack_valid = 1'b1; bus.pack_data = 8'h01; bus.pack_code = 5'b10011;
        pack_q.push_back(13'h000F);
        bus.check_valid = 1'b1; bus.check_block = 13'h000F;
        chk_q.push_back('{1'b0, 1'b0, 13'h000F});
        issue_lit(13'h002F, 1'b1, 1'b0, 13'h000F);
        issue_lit(13'h000E, 1'b1, 1'b0, 13'h000F);
        issue_lit(13'h006F, 1'b1, 1'b1, 13'h006F);
        issue_lit(13'h020F, 1'b1, 1'b0, 13'h000F);
        issue_lit(13'h000C, 1'b1, 1'b1, 13'h000C);
        issue(1'b0, '0, '0, 1'b0, '0);
        issue(1'b0, '0, '0, 1'b0, '0);

        // Asynchronous reset with a request in flight
        issue(1'b0, '0, '0, 1'b1, 13'h002F);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        drive_now(1'b0, '0, '0, 1'b1, 13'h000E);
        issue(1'b0, '0, '0, 1'b0, '0);

        // Exhaustive clean and single-error sweep, pack channel running alongside
        for (int d = 0; d < 256; d++) begin
            logic [BW-1:0] cw;
            cw = encode(DW'(d));
            issue(1'b1, DW'(d), code_of(cw), 1'b1, cw);
            for (int i = 0; i < BW; i++)
                issue(1'($urandom_range(0, 1)), DW'($urandom), PW'($urandom), 1'b1, cw ^ (BW'(1) << i));
        end

        // Random mix: raw blocks, single and double errors, idle cycles
        for (int n = 0; n < 600; n++) begin
            logic [BW-1:0] cw;
            int i, j, kind;
            cw   = encode(DW'($urandom));
            i    = $urandom_range(0, BW - 1);
            j    = (i + $urandom_range(1, BW - 1)) % BW;
            kind = $urandom_range(0, 3);
            case (kind)
                0: cw = BW'($urandom);
                1: cw = cw ^ (BW'(1) << i);
                2: cw = cw ^ (BW'(1) << i) ^ (BW'(1) << j);
                default: ;
            endcase
            issue(1'($urandom_range(0, 1)), DW'($urandom), PW'($urandom), 1'($urandom_range(0, 3) != 0), cw);
        end

`ifdef EXTENDED_HAMMING_BLOCK_CODEC_COUNTERS_EN
        // Drive the corrected counter past saturation
        for (int n = 0; n < 65540; n++)
            issue(1'b0, '0, '0, 1'b1, encode(DW'(n)) ^ (BW'(1) << (n % BW)));
`endif

        issue(1'b0, '0, '0, 1'b0, '0);
        repeat (3) @(negedge clock);
        check("pack_queue_drained",  32'(pack_q.size()), 0);
        check("check_queue_drained", 32'(chk_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
